dstack: RTL and testbench

Data-stack storage for the core0 pipeline. It consumes `movement`, `next_top`, `rotate` and `rotate_addr` from the dstack control stage and holds the stack as a register array. It returns `top`, `second`, `third` and `rotate_value` to that stage. It also tracks the number of valid entries and raises sticky overflow and underflow flags.

---
 rtl/dstack_pkg.sv | 9 +
 rtl/dstack.sv | 126 ++++++++++++
 tb/tb_dstack.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dstack_pkg.sv
// rtl/dstack_pkg.sv - shared core0 movement encodings for the data stack
package dstack_pkg;

  localparam logic [1:0] MOV_NONE = 2'b00;
  localparam logic [1:0] MOV_PUSH = 2'b01;
  localparam logic [1:0] MOV_POP1 = 2'b10;
  localparam logic [1:0] MOV_POP2 = 2'b11;

endpackage

// File: rtl/dstack.sv
// rtl/dstack.sv - core0 data-stack register array with depth tracking and sticky flags
module dstack
  import dstack_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic [1:0]            movement,
  input  logic [WORD_WIDTH-1:0] next_top,
  input  logic                  rotate,
  input  logic [4:0]            rotate_addr,
  input  logic                  flags_clear,
  output logic [WORD_WIDTH-1:0] top,
  output logic [WORD_WIDTH-1:0] second,
  output logic [WORD_WIDTH-1:0] third,
  output logic [WORD_WIDTH-1:0] rotate_value,
  output logic [5:0]            depth,
  output logic                  overflow,
  output logic                  underflow
);

  logic [WORD_WIDTH-1:0] e     [DEPTH];
  logic [WORD_WIDTH-1:0] e_nxt [DEPTH];
  logic [5:0]            depth_nxt;
  logic                  ovf_set;
  logic                  unf_set;

  assign e_nxt[0] = next_top;

  for (genvar i = 1; i < DEPTH; i++) begin : g_entry
    logic [WORD_WIDTH-1:0] pop1_val;
    logic [WORD_WIDTH-1:0] pop2_val;
    logic [WORD_WIDTH-1:0] nxt;
    logic                  in_rot;

    if (i + 1 < DEPTH) begin : g_p1
      assign pop1_val = e[i+1];
    end else begin : g_p1z
      assign pop1_val = '0;
    end

    if (i + 2 < DEPTH) begin : g_p2
      assign pop2_val = e[i+2];
    end else begin : g_p2z
      assign pop2_val = '0;
    end

    assign in_rot = ({1'b0, rotate_addr} >= 6'(i));

    always_comb begin
      nxt = e[i];
      if (rotate) begin
        if (in_rot) nxt = e[i-1];
      end else begin
        case (movement)
          MOV_PUSH: nxt = e[i-1];
          MOV_POP1: nxt = pop1_val;
          MOV_POP2: nxt = pop2_val;
          default:  nxt = e[i];
        endcase
      end
    end

    assign e_nxt[i] = nxt;
  end

  // A push with rotate_addr 0 is the plain (non-copy) push, so only real copies are range-checked.
  always_comb begin
    depth_nxt = depth;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (rotate) begin
      if ({1'b0, rotate_addr} >= depth) unf_set = 1'b1;
    end else begin
      case (movement)
        MOV_PUSH: begin
          if (depth == 6'(DEPTH)) ovf_set = 1'b1;
          else depth_nxt = depth + 6'd1;
          if (rotate_addr != 5'd0 && {1'b0, rotate_addr} >= depth) unf_set = 1'b1;
        end
        MOV_POP1: begin
          if (depth < 6'd2) begin
            unf_set   = 1'b1;
            depth_nxt = 6'd0;
          end else begin
            depth_nxt = depth - 6'd1;
          end
        end
        MOV_POP2: begin
          if (depth < 6'd3) begin
            unf_set   = 1'b1;
            depth_nxt = 6'd0;
          end else begin
            depth_nxt = depth - 6'd2;
          end
        end
        default: depth_nxt = depth;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) e[k] <= '0;
      depth     <= 6'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!halt) begin
      e         <= e_nxt;
      depth     <= depth_nxt;
      overflow  <= ovf_set | (overflow & ~flags_clear);
      underflow <= unf_set | (underflow & ~flags_clear);
    end
  end

  assign top    = e[0];
  assign second = e[1];
  assign third  = e[2];

  // Deliberately independent of next_top: the control stage feeds rotate_value back as next_top.
  assign rotate_value = (int'(rotate_addr) < DEPTH) ? e[rotate_addr] : '0;

endmodule

// File: tb/tb_dstack.sv
// tb/tb_dstack.sv - scoreboard bench for dstack with directed vectors
module tb_dstack;

  logic        clk;
  logic        reset;
  logic        halt;
  logic [1:0]  movement;
  logic [31:0] next_top;
  logic        rotate;
  logic [4:0]  rotate_addr;
  logic        flags_clear;
  logic [31:0] top, second, third, rotate_value;
  logic [5:0]  depth;
  logic        overflow, underflow;

  dstack #(.WORD_WIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .reset(reset), .halt(halt), .movement(movement),
    .next_top(next_top), .rotate(rotate), .rotate_addr(rotate_addr),
    .flags_clear(flags_clear), .top(top), .second(second), .third(third),
    .rotate_value(rotate_value), .depth(depth), .overflow(overflow),
    .underflow(underflow)
  );

  typedef struct {
    string       name;
    int          due;
    bit          is_rv;
    logic [31:0] rv;
    logic [31:0] t, s, th;
    logic [5:0]  d;
    logic        ov, un;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: compares every expectation that falls due in the current cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        x = q.pop_front();
        if (x.due < cyc) begin
          total_cnt++;
          $display("FAIL %s: checked at cycle %0d expected cycle %0d", x.name, cyc, x.due);
        end else if (x.is_rv) begin
          check({x.name, ".rotate_value"}, rotate_value, x.rv);
        end else begin
          check({x.name, ".top"}, top, x.t);
          check({x.name, ".second"}, second, x.s);
          check({x.name, ".third"}, third, x.th);
          check({x.name, ".depth"}, 32'(depth), 32'(x.d));
          check({x.name, ".overflow"}, 32'(overflow), 32'(x.ov));
          check({x.name, ".underflow"}, 32'(underflow), 32'(x.un));
        end
      end
    end
  end

  task automatic expect_state(string name, int due, logic [31:0] t, logic [31:0] s,
                              logic [31:0] th, logic [5:0] d, logic ov, logic un);
    exp_t x;
    x.name = name; x.due = due; x.is_rv = 1'b0; x.rv = '0;
    x.t = t; x.s = s; x.th = th; x.d = d; x.ov = ov; x.un = un;
    q.push_back(x);
  endtask

  // Called at posedge+1; the command takes effect at the next edge.
  task automatic step(string name, logic [1:0] mov, logic [31:0] nt, logic rot,
                      logic [4:0] addr, logic hlt, logic clr, logic rv_chk,
                      logic [31:0] rv_exp, logic [31:0] t, logic [31:0] s,
                      logic [31:0] th, logic [5:0] d, logic ov, logic un);
    exp_t x;
    movement = mov; next_top = nt; rotate = rot; rotate_addr = addr;
    halt = hlt; flags_clear = clr;
    if (rv_chk) begin
      x.name = name; x.due = cyc; x.is_rv = 1'b1; x.rv = rv_exp;
      x.t = '0; x.s = '0; x.th = '0; x.d = '0; x.ov = 1'b0; x.un = 1'b0;
      q.push_back(x);
    end
    expect_state(name, cyc + 1, t, s, th, d, ov, un);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; movement = 2'b00; next_top = '0;
    rotate = 1'b0; rotate_addr = '0; flags_clear = 1'b0;
    @(posedge clk);
    #1;
    expect_state("reset", cyc, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    //    name        mov    nt  rot addr hlt clr rvc rv   top sec thd dep ov un
    step("push1",     2'b01, 1,  0, 0,   0,  0,  0,  0,   1,  0,  0,  1,  0, 0);
    step("push2",     2'b01, 2,  0, 0,   0,  0,  0,  0,   2,  1,  0,  2,  0, 0);
    step("push3",     2'b01, 3,  0, 0,   0,  0,  0,  0,   3,  2,  1,  3,  0, 0);
    step("pop2",      2'b11, 1,  0, 0,   0,  0,  0,  0,   1,  0,  0,  1,  0, 0);
    step("pop1_unf",  2'b10, 0,  0, 0,   0,  0,  0,  0,   0,  0,  0,  0,  0, 1);
    step("clear1",    2'b00, 0,  0, 0,   0,  1,  0,  0,   0,  0,  0,  0,  0, 0);

    for (int k = 1; k <= 33; k++) begin
      step($sformatf("fill%0d", k), 2'b01, 32'(k), 0, 0, 0, 0, 0, 0,
           32'(k), (k >= 2) ? 32'(k - 1) : 32'd0, (k >= 3) ? 32'(k - 2) : 32'd0,
           (k >= 32) ? 6'd32 : 6'(k), (k == 33), 0);
    end

    step("e31",       2'b00, 33, 0, 31,  0,  0,  1,  2,   33, 32, 31, 32, 1, 0);
    step("e0",        2'b00, 33, 0, 0,   0,  0,  1,  33,  33, 32, 31, 32, 1, 0);
    step("clear2",    2'b00, 33, 0, 0,   0,  1,  0,  0,   33, 32, 31, 32, 0, 0);

    @(posedge clk);
    #3;
    reset = 1'b1;
    expect_state("midreset", cyc, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    step("push8",     2'b01, 8,  0, 0,   0,  0,  0,  0,   8,  0,  0,  1,  0, 0);
    step("push7",     2'b01, 7,  0, 0,   0,  0,  0,  0,   7,  8,  0,  2,  0, 0);
    step("push6",     2'b01, 6,  0, 0,   0,  0,  0,  0,   6,  7,  8,  3,  0, 0);
    step("push5",     2'b01, 5,  0, 0,   0,  0,  0,  0,   5,  6,  7,  4,  0, 0);
    step("rot3",      2'b00, 8,  1, 3,   0,  0,  1,  8,   8,  5,  6,  4,  0, 0);
    step("e3",        2'b00, 8,  0, 3,   0,  0,  1,  7,   8,  5,  6,  4,  0, 0);
    step("rot6_unf",  2'b00, 0,  1, 6,   0,  0,  1,  0,   0,  8,  5,  4,  0, 1);
    step("halt",      2'b01, 99, 0, 0,   1,  1,  0,  0,   0,  8,  5,  4,  0, 1);
    step("rot_push",  2'b01, 5,  1, 2,   0,  0,  1,  5,   5,  0,  8,  4,  0, 1);
    step("clear3",    2'b00, 5,  0, 0,   0,  1,  0,  0,   5,  0,  8,  4,  0, 0);
    step("copy_unf",  2'b01, 0,  0, 5,   0,  1,  1,  0,   0,  5,  0,  5,  0, 1);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
